// File: rtl/router_switch_allocator_if.sv
// router_switch_allocator_if: request, grant and crossbar bundle
// shared by the input buffers, the switch allocator and the crossbar.
interface router_switch_allocator_if #(
  parameter int NUM_INPUTS   = 5,
  parameter int NUM_OUTPUTS  = 5,
  parameter int ROUTE_WIDTH  = 3,
  parameter int IN_SEL_WIDTH = $clog2(NUM_INPUTS)
);
  logic [NUM_INPUTS-1:0]                    req_valid;
  logic [NUM_INPUTS-1:0][ROUTE_WIDTH-1:0]   req_port;
  logic [NUM_INPUTS-1:0]                    req_tail;
  logic [NUM_INPUTS-1:0][NUM_OUTPUTS-1:0]   disable_turns;
  logic [NUM_OUTPUTS-1:0]                   credit_in;
  logic [NUM_INPUTS-1:0]                    grant;
  logic [NUM_OUTPUTS-1:0]                   send_out;
  logic [NUM_OUTPUTS-1:0][IN_SEL_WIDTH-1:0] xbar_sel;
  logic [NUM_OUTPUTS-1:0]                   out_locked;
  logic                                     err_credit_overflow;
  logic                                     err_turn;

  modport master (
    output req_valid,
    output req_port,
    output req_tail,
    output disable_turns,
    output credit_in,
    input  grant,
    input  send_out,
    input  xbar_sel,
    input  out_locked,
    input  err_credit_overflow,
    input  err_turn
  );

  modport slave (
    input  req_valid,
    input  req_port,
    input  req_tail,
    input  disable_turns,
    input  credit_in,
    output grant,
    output send_out,
    output xbar_sel,
    output out_locked,
    output err_credit_overflow,
    output err_turn
  );
endinterface

// File: rtl/router_switch_allocator.sv
// router_switch_allocator: per-output round-robin switch allocator
// with wormhole output locking and downstream credit tracking.
module router_switch_allocator #(
  parameter int NUM_INPUTS   = 5,
  parameter int NUM_OUTPUTS  = 5,
  parameter int CREDIT_DEPTH = 1,
  parameter int ROUTE_WIDTH  = 3,
  parameter int IN_SEL_WIDTH = $clog2(NUM_INPUTS),
  parameter int CREDIT_WIDTH = $clog2(CREDIT_DEPTH+1)
) (
  input logic                      clk_noc,
  input logic                      rst_n,
  router_switch_allocator_if.slave sw
);
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  localparam logic [CREDIT_WIDTH-1:0] CRED_FULL =
    CREDIT_WIDTH'(CREDIT_DEPTH);
  localparam logic [IN_SEL_WIDTH-1:0] LAST_IN =
    IN_SEL_WIDTH'(NUM_INPUTS-1);

  logic [NUM_OUTPUTS-1:0] state_q, state_d;
  logic [NUM_OUTPUTS-1:0][IN_SEL_WIDTH-1:0] owner_q, owner_d;
  logic [NUM_OUTPUTS-1:0][IN_SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_OUTPUTS-1:0][CREDIT_WIDTH-1:0] credit_q, credit_d;
  logic [NUM_OUTPUTS-1:0] send_q, send_d;
  logic [NUM_OUTPUTS-1:0][IN_SEL_WIDTH-1:0] sel_q, sel_d;
  logic ovf_q, ovf_d;
  logic turn_q, turn_d;

  logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] elig;
  logic [NUM_OUTPUTS-1:0] win_vld;
  logic [NUM_OUTPUTS-1:0][IN_SEL_WIDTH-1:0] win_idx;
  logic [NUM_INPUTS-1:0] grant;
  int idx;

  // eligibility of every input for every output; reset gates all
  always_comb begin
    elig = '0;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        elig[o][i] = rst_n
          && sw.req_valid[i]
          && (sw.req_port[i] == ROUTE_WIDTH'(o))
          && !sw.disable_turns[i][o]
          && (credit_q[o] != '0)
          && ((state_q[o] == ST_IDLE)
              || (owner_q[o] == IN_SEL_WIDTH'(i)));
      end
    end
  end

  // round-robin pick: scan downward so the lowest offset wins last
  always_comb begin
    win_vld = '0;
    win_idx = '0;
    idx = 0;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_q[o]) + k;
        if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
        if (elig[o][idx]) begin
          win_vld[o] = 1'b1;
          win_idx[o] = IN_SEL_WIDTH'(idx);
        end
      end
    end
  end

  // fold per-output winners into the per-input dequeue strobe
  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      if (win_vld[o]) grant[win_idx[o]] = 1'b1;
    end
  end

  // lock, pointer, credit and error next-state
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    credit_d = credit_q;
    ovf_d    = ovf_q;
    turn_d   = turn_q;
    send_d   = win_vld;
    sel_d    = win_idx;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      if (win_vld[o]) begin
        if (state_q[o] == ST_IDLE) begin
          rr_ptr_d[o] = (win_idx[o] == LAST_IN)
            ? '0 : win_idx[o] + 1'b1;
        end
        state_d[o] = sw.req_tail[win_idx[o]]
          ? ST_IDLE : ST_LOCKED;
        owner_d[o] = win_idx[o];
      end
      unique case (1'b1)
        win_vld[o] && !sw.credit_in[o]:
          credit_d[o] = credit_q[o] - 1'b1;
        !win_vld[o] && sw.credit_in[o]: begin
          if (credit_q[o] == CRED_FULL) ovf_d = 1'b1;
          else credit_d[o] = credit_q[o] + 1'b1;
        end
        default: ;
      endcase
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (sw.req_valid[i]
            && (sw.req_port[i] == ROUTE_WIDTH'(o))
            && sw.disable_turns[i][o]) begin
          turn_d = 1'b1;
        end
      end
    end
  end

  // state registers; reset drops any held lock
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      credit_q <= {NUM_OUTPUTS{CRED_FULL}};
      send_q   <= '0;
      sel_q    <= '0;
      ovf_q    <= 1'b0;
      turn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      send_q   <= send_d;
      sel_q    <= sel_d;
      ovf_q    <= ovf_d;
      turn_q   <= turn_d;
    end
  end

  assign sw.grant               = grant;
  assign sw.send_out            = send_q;
  assign sw.xbar_sel            = sel_q;
  assign sw.out_locked          = state_q;
  assign sw.err_credit_overflow = ovf_q;
  assign sw.err_turn            = turn_q;
endmodule

// File: tb/tb_router_switch_allocator.sv
// tb_router_switch_allocator: vector table, directed corner cases
// and random traffic against a packet-level allocator model.
module tb_router_switch_allocator;
  localparam int NI = 5;
  localparam int NO = 5;
  localparam int CD = 2;
  localparam int RW = 3;

  logic clk_noc = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_noc = ~clk_noc;

  router_switch_allocator_if #(
    .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .ROUTE_WIDTH(RW)
  ) bus ();

  router_switch_allocator #(
    .NUM_INPUTS(NI), .NUM_OUTPUTS(NO),
    .CREDIT_DEPTH(CD), .ROUTE_WIDTH(RW)
  ) dut (
    .clk_noc(clk_noc),
    .rst_n(rst_n),
    .sw(bus)
  );

  typedef struct {
    logic [NI-1:0] vld;
    int            port;
    logic [NI-1:0] tail;
    logic [NO-1:0] cred;
    logic [NI-1:0] exp_g;
  } vec_t;

  vec_t tbl[$];

  int m_cred[NO];
  int m_owner[NO];
  int m_rr[NO];
  bit m_send[NO];
  int m_sel[NO];
  bit m_ovf;
  bit m_turn;

  int checks = 0;
  int passed = 0;
  logic [NI-1:0] last_grant;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t v(logic [NI-1:0] vld, int port,
    logic [NI-1:0] tail, logic [NO-1:0] cred, logic [NI-1:0] g);
    vec_t r;
    r.vld = vld; r.port = port; r.tail = tail;
    r.cred = cred; r.exp_g = g;
    return r;
  endfunction

  task automatic model_reset();
    for (int o = 0; o < NO; o++) begin
      m_cred[o] = CD; m_owner[o] = -1; m_rr[o] = 0;
      m_send[o] = 0; m_sel[o] = 0;
    end
    m_ovf = 0; m_turn = 0;
  endtask

  task automatic drive(logic [NI-1:0] vld, int port,
    logic [NI-1:0] tail, logic [NO-1:0] cred);
    bus.req_valid = vld;
    for (int i = 0; i < NI; i++) bus.req_port[i] = RW'(port);
    bus.req_tail  = tail;
    bus.credit_in = cred;
  endtask

  // one clock: predict, compare at negedge, advance model
  task automatic tick();
    int win[NO];
    int best, d;
    logic [NI-1:0] eg;
    logic [NO-1:0] es, el;
    @(negedge clk_noc);
    if (!rst_n) model_reset();
    eg = '0;
    for (int o = 0; o < NO; o++) begin
      win[o] = -1;
      best = NI;
      if (rst_n) begin
        for (int i = 0; i < NI; i++) begin
          if (bus.req_valid[i] && int'(bus.req_port[i]) == o
              && !bus.disable_turns[i][o] && m_cred[o] > 0
              && (m_owner[o] < 0 || m_owner[o] == i)) begin
            d = (i - m_rr[o] + NI) % NI;
            if (d < best) begin best = d; win[o] = i; end
          end
        end
      end
      if (win[o] >= 0) eg[win[o]] = 1'b1;
      es[o] = m_send[o];
      el[o] = (m_owner[o] >= 0);
    end
    last_grant = bus.grant;
    chk("grant", bus.grant, eg);
    chk("send_out", bus.send_out, es);
    chk("out_locked", bus.out_locked, el);
    for (int o = 0; o < NO; o++) begin
      if (m_send[o])
        chk($sformatf("xbar_sel[%0d]", o), bus.xbar_sel[o], m_sel[o]);
    end
    chk("err_credit_overflow", bus.err_credit_overflow, m_ovf);
    chk("err_turn", bus.err_turn, m_turn);
    if (rst_n) begin
      for (int o = 0; o < NO; o++) begin
        m_send[o] = (win[o] >= 0);
        m_sel[o] = (win[o] >= 0) ? win[o] : 0;
        if (win[o] >= 0) begin
          if (m_owner[o] < 0) m_rr[o] = (win[o] + 1) % NI;
          m_owner[o] = bus.req_tail[win[o]] ? -1 : win[o];
        end
        if (win[o] >= 0 && !bus.credit_in[o]) m_cred[o]--;
        else if (win[o] < 0 && bus.credit_in[o]) begin
          if (m_cred[o] == CD) m_ovf = 1;
          else m_cred[o]++;
        end
        for (int i = 0; i < NI; i++) begin
          if (bus.req_valid[i] && int'(bus.req_port[i]) == o
              && bus.disable_turns[i][o]) m_turn = 1;
        end
      end
    end
    @(posedge clk_noc);
    #1;
  endtask

  initial begin
    model_reset();
    bus.disable_turns = '0;
    drive('0, 0, '0, '0);

    // reset with every input requesting its own output
    bus.req_valid = '1;
    for (int i = 0; i < NI; i++) bus.req_port[i] = RW'(i);
    bus.req_tail  = '1;
    bus.credit_in = '1;
    repeat (3) tick();
    chk("reset grant", last_grant, 0);
    rst_n = 1'b1;
    tick();
    chk("first active grant", last_grant, 5'b11111);

    // round robin on output 3: order 1,2,3,1
    tbl.push_back(v(5'b01110, 3, '1, 5'b01000, 5'b00010));
    tbl.push_back(v(5'b01110, 3, '1, 5'b01000, 5'b00100));
    tbl.push_back(v(5'b01110, 3, '1, 5'b01000, 5'b01000));
    tbl.push_back(v(5'b01110, 3, '1, 5'b01000, 5'b00010));
    // wormhole: input 2 four flits on output 1, input 4 waits
    tbl.push_back(v(5'b10100, 1, 5'b10000, 5'b00010, 5'b00100));
    tbl.push_back(v(5'b10100, 1, 5'b10000, 5'b00010, 5'b00100));
    tbl.push_back(v(5'b10100, 1, 5'b10000, 5'b00010, 5'b00100));
    tbl.push_back(v(5'b10100, 1, 5'b10100, 5'b00010, 5'b00100));
    tbl.push_back(v(5'b10000, 1, 5'b10000, 5'b00010, 5'b10000));
    // out-of-range output indices are ignored
    tbl.push_back(v(5'b00010, 6, '1, '0, '0));
    tbl.push_back(v(5'b00001, 5, '1, '0, '0));
    // credits on output 2 from input 0
    tbl.push_back(v(5'b00001, 2, '1, '0, 5'b00001));
    tbl.push_back(v(5'b00001, 2, '1, '0, 5'b00001));
    tbl.push_back(v(5'b00001, 2, '1, '0, '0));
    tbl.push_back(v(5'b00001, 2, '1, 5'b00100, '0));
    tbl.push_back(v(5'b00001, 2, '1, '0, 5'b00001));
    tbl.push_back(v(5'b00001, 2, '1, 5'b00100, '0));
    tbl.push_back(v(5'b00001, 2, '1, 5'b00100, 5'b00001));
    tbl.push_back(v(5'b00001, 2, '1, '0, 5'b00001));
    tbl.push_back(v(5'b00001, 2, '1, '0, '0));
    // refill, then one extra credit overflows and saturates
    tbl.push_back(v('0, 2, '0, 5'b00100, '0));
    tbl.push_back(v('0, 2, '0, 5'b00100, '0));
    tbl.push_back(v('0, 2, '0, 5'b00100, '0));
    tbl.push_back(v(5'b00001, 2, '1, '0, 5'b00001));
    tbl.push_back(v(5'b00001, 2, '1, '0, 5'b00001));
    tbl.push_back(v(5'b00001, 2, '1, '0, '0));

    foreach (tbl[n]) begin
      drive(tbl[n].vld, tbl[n].port, tbl[n].tail, tbl[n].cred);
      tick();
      chk($sformatf("vec%0d grant", n), last_grant, tbl[n].exp_g);
    end
    chk("overflow flag", bus.err_credit_overflow, 1);

    // disabled turn 3->3 is never granted and flags an error
    bus.disable_turns[3][3] = 1'b1;
    drive(5'b01000, 3, '1, '0);
    repeat (3) begin
      tick();
      chk("disabled turn grant", last_grant, 0);
    end
    chk("err_turn flag", bus.err_turn, 1);
    bus.disable_turns = '0;

    // reset while output 2 is held mid-packet
    drive('0, 2, '0, 5'b00100);
    tick();
    drive(5'b00001, 2, '0, '0);
    tick();
    chk("lock head grant", last_grant, 5'b00001);
    chk("locked before reset", bus.out_locked[2], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("lock dropped by reset", bus.out_locked[2], 0);
    chk("grant in reset", bus.grant, 0);
    tick();
    rst_n = 1'b1;
    drive(5'b01000, 2, 5'b01000, '0);
    tick();
    chk("new owner after reset", last_grant, 5'b01000);

    // random traffic against the model
    bus.disable_turns[$urandom_range(0, NI-1)][$urandom_range(0, NO-1)]
      = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) begin
        bus.req_valid[i] = ($urandom_range(0, 3) != 0);
        bus.req_tail[i]  = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 9) == 0)
          bus.req_port[i] = RW'($urandom_range(5, 7));
        else
          bus.req_port[i] = RW'($urandom_range(0, NO-1));
      end
      for (int o = 0; o < NO; o++)
        bus.credit_in[o] = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
